// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, owner IDs and line geometry helper for line-memory arbitration
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WAIT_WR = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  function automatic int offset_bits(input int line_size);
    return $clog2(line_size);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational 2-way picker; LINE_ARB_DPRIO_EN selects fixed priority to port 1
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef LINE_ARB_DPRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (eligible[1])      grant = 2'b10;
    else if (eligible[0]) grant = 2'b01;
  end
`else
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port that did not win last time goes next.
      2'b11:   grant = (last_grant == REQ_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - shares one line-granular DataMemory between I-cache (req0) and D-cache (req1)
// Optional LINE_ARB_DPRIO_EN: D-cache always wins ties instead of round-robin.
module line_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_SIZE  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rq0_valid,
  input  logic [ADDR_WIDTH-1:0]  rq0_addr,
  input  logic                   rq0_read,
  input  logic                   rq0_write,
  input  logic [LINE_SIZE*8-1:0] rq0_din,
  output logic                   rq0_ready,
  output logic                   rq0_out_valid,
  output logic [LINE_SIZE*8-1:0] rq0_dout,
  input  logic                   rq1_valid,
  input  logic [ADDR_WIDTH-1:0]  rq1_addr,
  input  logic                   rq1_read,
  input  logic                   rq1_write,
  input  logic [LINE_SIZE*8-1:0] rq1_din,
  output logic                   rq1_ready,
  output logic                   rq1_out_valid,
  output logic [LINE_SIZE*8-1:0] rq1_dout,
  output logic                   mem_input_valid,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_SIZE*8-1:0] mem_din,
  input  logic                   mem_output_valid,
  input  logic [LINE_SIZE*8-1:0] mem_dout,
  input  logic                   mem_ready
);

  localparam int OFFSET_BITS = offset_bits(LINE_SIZE);

  state_t                 state, state_next;
  logic                   owner;
  logic                   last_grant;
  logic [1:0]             eligible;
  logic [1:0]             grant;
  logic                   take;
  logic                   to_resp;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_write;
  logic [LINE_SIZE*8-1:0] sel_din;
  logic [LINE_SIZE*8-1:0] resp_data;

  assign eligible[0] = rq0_valid && (rq0_read || rq0_write);
  assign eligible[1] = rq1_valid && (rq1_read || rq1_write);

  rr_pick2 u_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Read+write together is handled as a write.
  assign sel_addr  = grant[1] ? rq1_addr  : rq0_addr;
  assign sel_write = grant[1] ? rq1_write : rq0_write;
  assign sel_din   = grant[1] ? rq1_din   : rq0_din;
  assign resp_data = (state == WAIT_RD) ? mem_dout : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    rq0_ready  = 1'b0;
    rq1_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_ready && (grant != 2'b00)) begin
          take       = 1'b1;
          rq0_ready  = grant[0];
          rq1_ready  = grant[1];
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = mem_write ? WAIT_WR : WAIT_RD;
      WAIT_RD: if (mem_output_valid) state_next = RESP;
      WAIT_WR: if (mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign to_resp = (state != RESP) && (state_next == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      owner           <= REQ_I;
      last_grant      <= REQ_D;
      mem_input_valid <= 1'b0;
      mem_addr        <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_din         <= '0;
      rq0_out_valid   <= 1'b0;
      rq1_out_valid   <= 1'b0;
      rq0_dout        <= '0;
      rq1_dout        <= '0;
    end else begin
      mem_input_valid <= 1'b0;
      rq0_out_valid   <= 1'b0;
      rq1_out_valid   <= 1'b0;
      if (take) begin
        owner           <= grant[1];
        last_grant      <= grant[1];
        mem_input_valid <= 1'b1;
        mem_addr        <= sel_addr >> OFFSET_BITS;
        mem_read        <= !sel_write;
        mem_write       <= sel_write;
        mem_din         <= sel_din;
      end
      if (to_resp) begin
        if (owner == REQ_D) begin
          rq1_out_valid <= 1'b1;
          rq1_dout      <= resp_data;
        end else begin
          rq0_out_valid <= 1'b1;
          rq0_dout      <= resp_data;
        end
      end
    end
  end

  a_rq0_both_ops : assert property (@(posedge clk) disable iff (reset)
    !(rq0_valid && rq0_read && rq0_write))
    else $error("rq0 requested read and write together; treated as write");
  a_rq1_both_ops : assert property (@(posedge clk) disable iff (reset)
    !(rq1_valid && rq1_read && rq1_write))
    else $error("rq1 requested read and write together; treated as write");

endmodule
